// File: rtl/tsc_mem_access_ctrl_pkg.sv
// tsc_mem_access_ctrl_pkg: shared widths, defaults and FSM state encodings
package tsc_mem_access_ctrl_pkg;
    localparam int WORD_SIZE_DEF = 16;
    localparam int ADDR_SIZE_DEF = 16;
    localparam int TIMEOUT_DEF   = 255;
    localparam int CNT_SIZE_DEF  = 16;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/tsc_mem_access_ctrl_if.sv
// tsc_mem_access_ctrl_if: CPU-side request/response channel of the memory sequencer
interface tsc_mem_access_ctrl_if
    import tsc_mem_access_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 rsp_error;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/tsc_mem_access_ctrl_wait_timer.sv
// tsc_wait_timer: clearable wait counter flagging the last allowed handshake cycle
module tsc_wait_timer
    import tsc_mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (en) cnt <= cnt + CW'(1);
    end
    // TIMEOUT of 0 disables the terminal count entirely
    assign tc = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/tsc_mem_access_ctrl.sv
// tsc_mem_access_ctrl: FSM sequencing CPU reads/writes onto the shared memory bus
// with handshake timeout, error reporting and a successful-access counter.
module tsc_mem_access_ctrl
    import tsc_mem_access_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    tsc_mem_access_ctrl_if.slave cpu,
    output logic                 readM,
    output logic                 writeM,
    output logic [ADDR_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic [CNT_SIZE-1:0]  num_access
);
    logic [1:0]           state;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 err_q;
    logic                 busy;
    logic                 hs;
    logic                 tc;
    assign busy = (state == ST_READ) || (state == ST_WRITE);
    assign hs   = (state == ST_READ && inputReady) || (state == ST_WRITE && ackOutput);
    tsc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (!busy),
        .en    (busy && !hs),
        .tc    (tc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            num_access <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cpu.req_valid) begin
                    addr_q  <= cpu.req_addr;
                    wdata_q <= cpu.req_wdata;
                    state   <= cpu.req_write ? ST_WRITE : ST_READ;
                end
                ST_READ, ST_WRITE: if (hs || tc) begin
                    // a handshake on the timeout edge still counts as success
                    rdata_q <= (hs && state == ST_READ) ? data : '0;
                    err_q   <= !hs;
                    state   <= ST_RESP;
                end
                default: begin
                    if (!err_q) num_access <= num_access + CNT_SIZE'(1);
                    state <= ST_IDLE;
                end
            endcase
        end
    end
    assign readM         = state == ST_READ;
    assign writeM        = state == ST_WRITE;
    assign address       = addr_q;
    assign data          = (state == ST_WRITE) ? wdata_q : 'z;
    assign cpu.req_ready = state == ST_IDLE;
    assign cpu.rsp_valid = state == ST_RESP;
    assign cpu.rsp_rdata = rdata_q;
    assign cpu.rsp_error = err_q;
endmodule

// File: tb/tb_tsc_mem_access_ctrl.sv
// tb_tsc_mem_access_ctrl: directed bench with an expected-response queue for tsc_mem_access_ctrl
module tb_tsc_mem_access_ctrl;
    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        readM, writeM, inputReady = 1'b0, ackOutput = 1'b0;
    logic [15:0] address;
    logic [1:0]  num_access;
    logic        mem_drv = 1'b0;
    logic [15:0] mem_val = '0;
    wire  [15:0] data;
    int          checks = 0;
    int          failures = 0;
    int          exp_cnt = 0;
    exp_t        q[$];

    tsc_mem_access_ctrl_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) cpu_if ();

    tsc_mem_access_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(16), .TIMEOUT(8), .CNT_SIZE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_if.slave),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .ackOutput  (ackOutput),
        .num_access (num_access)
    );

    assign data = mem_drv ? mem_val : 'z;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] rd, input logic err, input logic push);
        exp_t e;
        cpu_if.req_valid = 1'b1;
        cpu_if.req_write = wr;
        cpu_if.req_addr  = addr;
        cpu_if.req_wdata = wd;
        chk("req_ready_idle", cpu_if.req_ready, 1);
        tick();
        cpu_if.req_valid = 1'b0;
        e.rdata = rd;
        e.err   = err;
        if (push) q.push_back(e);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        exp_t e;
        while (!cpu_if.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, cpu_if.rsp_valid, 1);
        if (cpu_if.rsp_valid && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_rdata"}, cpu_if.rsp_rdata, e.rdata);
            chk({tag, "_error"}, cpu_if.rsp_error, e.err);
        end
    endtask

    task automatic finish_rsp(input string tag, input logic ok);
        tick();
        if (ok) exp_cnt = (exp_cnt + 1) % 4;
        chk({tag, "_pulse_end"}, cpu_if.rsp_valid, 0);
        chk({tag, "_ready"}, cpu_if.req_ready, 1);
        chk({tag, "_num_access"}, num_access, exp_cnt);
    endtask

    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] val,
                             input int waits, input string tag);
        issue(wr, addr, val, wr ? 16'h0 : val, 1'b0, 1'b1);
        repeat (waits) tick();
        if (wr) ackOutput = 1'b1;
        else begin
            inputReady = 1'b1;
            mem_drv    = 1'b1;
            mem_val    = val;
        end
        tick();
        ackOutput  = 1'b0;
        inputReady = 1'b0;
        mem_drv    = 1'b0;
        wait_rsp(tag);
        finish_rsp(tag, 1'b1);
    endtask

    initial begin
        int n;
        cpu_if.req_valid = 1'b0;
        cpu_if.req_write = 1'b0;
        cpu_if.req_addr  = '0;
        cpu_if.req_wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_req_ready", cpu_if.req_ready, 1);
        chk("rst_readM", readM, 0);
        chk("rst_writeM", writeM, 0);
        chk("rst_address", address, 0);
        chk("rst_rsp_valid", cpu_if.rsp_valid, 0);
        chk("rst_rsp_error", cpu_if.rsp_error, 0);
        chk("rst_rsp_rdata", cpu_if.rsp_rdata, 0);
        chk("rst_num_access", num_access, 0);

        // read with immediate ready
        issue(1'b0, 16'h0010, 16'h0, 16'h6C01, 1'b0, 1'b1);
        chk("rd_readM", readM, 1);
        chk("rd_address", address, 16'h0010);
        chk("rd_ready_busy", cpu_if.req_ready, 0);
        inputReady = 1'b1;
        mem_drv    = 1'b1;
        mem_val    = 16'h6C01;
        tick();
        inputReady = 1'b0;
        mem_drv    = 1'b0;
        chk("rd_readM_resp", readM, 0);
        wait_rsp("rd");
        finish_rsp("rd", 1'b1);

        // write with four wait cycles
        issue(1'b1, 16'h0020, 16'hBEEF, 16'h0, 1'b0, 1'b1);
        chk("wr_writeM", writeM, 1);
        chk("wr_data", data, 16'hBEEF);
        chk("wr_address", address, 16'h0020);
        repeat (4) tick();
        chk("wr_writeM_wait", writeM, 1);
        chk("wr_data_wait", data, 16'hBEEF);
        ackOutput = 1'b1;
        tick();
        ackOutput = 1'b0;
        wait_rsp("wr");
        chk("wr_writeM_resp", writeM, 0);
        mem_drv = 1'b1;
        mem_val = 16'h1234;
        #1;
        chk("wr_bus_released", data, 16'h1234);
        mem_drv = 1'b0;
        finish_rsp("wr", 1'b1);

        // read timeout: readM high for exactly TIMEOUT cycles
        issue(1'b0, 16'h0030, 16'h0, 16'h0, 1'b1, 1'b1);
        n = 0;
        while (readM && n < 20) begin
            n++;
            tick();
        end
        chk("to_readM_cycles", n, 8);
        wait_rsp("to");
        finish_rsp("to", 1'b0);

        // handshake on the timeout edge wins
        issue(1'b0, 16'h0040, 16'h0, 16'hA5A5, 1'b0, 1'b1);
        repeat (7) tick();
        chk("toe_readM", readM, 1);
        inputReady = 1'b1;
        mem_drv    = 1'b1;
        mem_val    = 16'hA5A5;
        tick();
        inputReady = 1'b0;
        mem_drv    = 1'b0;
        wait_rsp("toe");
        finish_rsp("toe", 1'b1);

        // reset two cycles into a read aborts it silently
        issue(1'b0, 16'h0050, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_cnt = 0;
        chk("mr_readM", readM, 0);
        chk("mr_req_ready", cpu_if.req_ready, 1);
        chk("mr_rsp_valid", cpu_if.rsp_valid, 0);
        chk("mr_num_access", num_access, 0);
        chk("mr_address", address, 0);
        mem_drv = 1'b1;
        mem_val = 16'h5A5A;
        #1;
        chk("mr_bus_released", data, 16'h5A5A);
        mem_drv = 1'b0;
        reset = 1'b0;
        tick();
        chk("mr_no_rsp", cpu_if.rsp_valid, 0);

        // spurious handshakes are ignored
        inputReady = 1'b1;
        repeat (2) tick();
        inputReady = 1'b0;
        chk("sp_idle_ready", cpu_if.req_ready, 1);
        chk("sp_idle_rsp", cpu_if.rsp_valid, 0);
        issue(1'b0, 16'h0060, 16'h0, 16'h1111, 1'b0, 1'b1);
        ackOutput = 1'b1;
        tick();
        ackOutput = 1'b0;
        chk("sp_rd_still_readM", readM, 1);
        chk("sp_rd_no_rsp", cpu_if.rsp_valid, 0);
        inputReady = 1'b1;
        mem_drv    = 1'b1;
        mem_val    = 16'h1111;
        tick();
        inputReady = 1'b0;
        mem_drv    = 1'b0;
        wait_rsp("sp");
        finish_rsp("sp", 1'b1);

        // four more accesses: five successes wrap the 2-bit counter to 1
        do_access(1'b1, 16'h0070, 16'h2222, 0, "wrap0");
        do_access(1'b0, 16'h0071, 16'h3333, 2, "wrap1");
        do_access(1'b1, 16'h0072, 16'h4444, 1, "wrap2");
        do_access(1'b0, 16'h0073, 16'h5555, 0, "wrap3");
        chk("wrap_final", num_access, 1);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
